// File: rtl/digdug_bus_pkg.sv
// digdug_bus_pkg: shared types and defaults
// for the three-Z80 bus slot scheduler.
package digdug_bus_pkg;

    typedef enum logic [1:0] {
        PICK,
        ACCESS,
        WAIT
    } bus_st_t;

    localparam int NCPU_DEF    = 3;
    localparam int DIV_DEF     = 4;
    localparam int MAXWAIT_DEF = 7;

    function automatic int phase_w(input int div);
        return (div < 3) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/digdug_rr_pick.sv
// digdug_rr_pick: combinational round-robin finder,
// first eligible requester after the pointer.
module digdug_rr_pick
    import digdug_bus_pkg::*;
#(
    parameter int N = NCPU_DEF
) (
    input  logic [$clog2(N)-1:0] ptr,
    input  logic [N-1:0]         elig,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 none
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] c;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        none = 1'b1;
        c    = '0;
        for (int k = 1; k <= N; k++) begin
            c = IW'((int'(ptr) + k) % N);
            if (none && elig[c]) begin
                none   = 1'b0;
                idx    = c;
                gnt[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/digdug_bus_sched.sv
// digdug_bus_sched: round-robin slot scheduler for
// the shared CPU-to-device bus, with read wait states.
module digdug_bus_sched
    import digdug_bus_pkg::*;
#(
    parameter int NCPU    = NCPU_DEF,
    parameter int DIV     = DIV_DEF,
    parameter int MAXWAIT = MAXWAIT_DEF
) (
    input  logic            MCLK,
    input  logic            RST_N,
    input  logic [NCPU-1:0] CPU_RST,
    input  logic [NCPU-1:0] REQ_RD,
    input  logic [NCPU-1:0] REQ_WR,
    input  logic            DEV_DV,
    output logic [NCPU-1:0] GNT,
    output logic [NCPU-1:0] CPU_CE,
    output logic            DEV_RD,
    output logic            DEV_WR,
    output logic            SLOT_ST,
    output logic            TIMEOUT
);

    localparam int PW = phase_w(DIV);
    localparam int IW = $clog2(NCPU);

    bus_st_t         st;
    logic [PW-1:0]   phase;
    logic [7:0]      wcnt;
    logic [IW-1:0]   ptr;
    logic [NCPU-1:0] gnt_q;

    logic [NCPU-1:0] p_gnt;
    logic [IW-1:0]   p_idx;
    logic            p_none;

    logic [NCPU-1:0] cur;
    logic            rd, wr, abort, last, tmo, done;

    digdug_rr_pick #(.N(NCPU)) u_pick (
        .ptr  (ptr),
        .elig (~CPU_RST),
        .gnt  (p_gnt),
        .idx  (p_idx),
        .none (p_none)
    );

    // The grant is live from the PICK cycle so the mux settles early.
    assign cur   = (st == PICK) ? p_gnt : gnt_q;
    assign rd    = |(cur & REQ_RD & ~REQ_WR);
    assign wr    = |(cur & REQ_WR);
    assign abort = (st != PICK) && |(gnt_q & CPU_RST);
    assign last  = (st == ACCESS) && (phase == PW'(DIV - 1));
    assign tmo   = (st == WAIT) && !DEV_DV
                && (wcnt == 8'(MAXWAIT - 1));
    assign done  = !abort
                && ((last && (!rd || DEV_DV))
                 || ((st == WAIT) && (DEV_DV || tmo)));

    assign GNT     = RST_N ? cur : '0;
    assign CPU_CE  = (RST_N && done) ? gnt_q : '0;
    assign DEV_RD  = RST_N && rd;
    assign DEV_WR  = RST_N && last && wr && !abort;
    assign SLOT_ST = RST_N && (st == PICK);
    assign TIMEOUT = RST_N && tmo && !abort;

    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            st    <= PICK;
            phase <= '0;
            wcnt  <= '0;
            ptr   <= IW'(NCPU - 1);
            gnt_q <= '0;
        end else begin
            unique case (st)
                PICK: begin
                    gnt_q <= p_gnt;
                    if (!p_none) ptr <= p_idx;
                    phase <= PW'(1);
                    st    <= ACCESS;
                end
                ACCESS: begin
                    if (abort || (last && done)) begin
                        st    <= PICK;
                        phase <= '0;
                    end else if (last) begin
                        st   <= WAIT;
                        wcnt <= '0;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                WAIT: begin
                    if (abort || done) begin
                        st    <= PICK;
                        phase <= '0;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                default: st <= PICK;
            endcase
        end
    end

endmodule

// File: tb/tb_digdug_bus_sched.sv
// tb_digdug_bus_sched: random stimulus against a
// slot-timeline reference model.
module tb_digdug_bus_sched;

    localparam int N  = 3;
    localparam int D  = 4;
    localparam int MW = 7;

    logic         MCLK = 1'b0;
    logic         RST_N;
    logic [N-1:0] CPU_RST;
    logic [N-1:0] REQ_RD;
    logic [N-1:0] REQ_WR;
    logic         DEV_DV;
    logic [N-1:0] GNT;
    logic [N-1:0] CPU_CE;
    logic         DEV_RD;
    logic         DEV_WR;
    logic         SLOT_ST;
    logic         TIMEOUT;

    int n_cmp = 0;
    int n_bad = 0;

    // m_t: MCLK index within the current slot, m_g: granted CPU or -1
    int m_t;
    int m_g;
    int m_ptr;

    always #5 MCLK = ~MCLK;

    digdug_bus_sched #(
        .NCPU    (N),
        .DIV     (D),
        .MAXWAIT (MW)
    ) dut (
        .MCLK    (MCLK),
        .RST_N   (RST_N),
        .CPU_RST (CPU_RST),
        .REQ_RD  (REQ_RD),
        .REQ_WR  (REQ_WR),
        .DEV_DV  (DEV_DV),
        .GNT     (GNT),
        .CPU_CE  (CPU_CE),
        .DEV_RD  (DEV_RD),
        .DEV_WR  (DEV_WR),
        .SLOT_ST (SLOT_ST),
        .TIMEOUT (TIMEOUT)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t   = 0;
        m_g   = -1;
        m_ptr = N - 1;
    endtask

    task automatic chk_zero();
        chk("rst_gnt", 32'(GNT), 0);
        chk("rst_ce", 32'(CPU_CE), 0);
        chk("rst_rd", 32'(DEV_RD), 0);
        chk("rst_wr", 32'(DEV_WR), 0);
        chk("rst_slot", 32'(SLOT_ST), 0);
        chk("rst_to", 32'(TIMEOUT), 0);
    endtask

    task automatic step();
        logic [N-1:0] one;
        logic [N-1:0] eg;
        logic [N-1:0] ec;
        bit ab, rdp, wrp, fin, to;
        int wc, c;
        one = 1;
        @(negedge MCLK);
        if (m_t == 0) begin
            m_g = -1;
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (m_g < 0 && !CPU_RST[c]) m_g = c;
            end
        end
        eg  = (m_g >= 0) ? (one << m_g) : '0;
        ab  = (m_t > 0) && (m_g >= 0) && CPU_RST[m_g];
        rdp = (m_g >= 0) && REQ_RD[m_g] && !REQ_WR[m_g];
        wrp = (m_g >= 0) && REQ_WR[m_g];
        wc  = m_t - (D - 1);
        fin = !ab && (((m_t == D - 1) && (!rdp || DEV_DV))
                   || ((wc >= 1) && (DEV_DV || wc == MW)));
        to  = !ab && (wc >= 1) && !DEV_DV && (wc == MW);
        ec  = (fin && m_g >= 0) ? (one << m_g) : '0;
        chk("gnt", 32'(GNT), 32'(eg));
        chk("ce", 32'(CPU_CE), 32'(ec));
        chk("dev_rd", 32'(DEV_RD), 32'(rdp));
        chk("dev_wr", 32'(DEV_WR),
            32'(!ab && (m_t == D - 1) && wrp));
        chk("slot_st", 32'(SLOT_ST), 32'(m_t == 0));
        chk("timeout", 32'(TIMEOUT), 32'(to));
        if (m_t == 0 && m_g >= 0) m_ptr = m_g;
        m_t = (ab || fin) ? 0 : m_t + 1;
        @(posedge MCLK);
        #1;
    endtask

    task automatic run(input int cyc, input int rst_p,
                       input int dv_p, input int rd_p,
                       input int wr_p);
        for (int i = 0; i < cyc; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(99) < rst_p)
                    CPU_RST[b] = ~CPU_RST[b];
                if (m_t == 0) begin
                    REQ_RD[b] = ($urandom_range(99) < rd_p);
                    REQ_WR[b] = ($urandom_range(99) < wr_p);
                end
            end
            DEV_DV = ($urandom_range(99) < dv_p);
            step();
        end
    endtask

    initial begin
        RST_N   = 1'b1;
        CPU_RST = '0;
        REQ_RD  = '0;
        REQ_WR  = '0;
        DEV_DV  = 1'b0;
        #1 RST_N = 1'b0;
        @(posedge MCLK);
        @(posedge MCLK);
        #1;
        chk_zero();
        RST_N = 1'b1;
        model_reset();

        run(40, 0, 0, 0, 0);
        CPU_RST = 3'b010;
        run(40, 0, 0, 0, 0);
        CPU_RST = '0;
        run(2000, 3, 30, 50, 30);
        CPU_RST = '0;
        run(200, 0, 0, 100, 0);
        run(200, 0, 10, 60, 20);
        CPU_RST = 3'b111;
        run(40, 0, 30, 50, 30);

        CPU_RST = '0;
        begin
            int n;
            n = 0;
            while (m_t < D && n < 60) begin
                REQ_RD = '1;
                REQ_WR = '0;
                DEV_DV = 1'b0;
                step();
                n++;
            end
            chk("reach_wait", 32'(m_t >= D), 1);
        end
        RST_N = 1'b0;
        #1;
        chk_zero();
        @(posedge MCLK);
        #1;
        RST_N  = 1'b1;
        REQ_RD = '0;
        model_reset();
        run(30, 0, 30, 50, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/digdug_bus_sched.md
Name: digdug_bus_sched

Overview:
- Round-robin time-slot scheduler for the shared CPU-to-device bus of the three-Z80 core cluster.
- Generates the per-CPU clock enables and a one-hot bus grant, and stretches a slot with wait states when a device read is not yet valid.
- Skips CPUs that are held in reset.
- Sits between the three CPU cores and the device bus mux, which selects on GNT. It replaces the fixed free-running slot rotation.

Parameters:
NCPU, 3, number of requesting CPUs (2..8)
DIV, 4, MCLK cycles per nominal slot (>=2)
MAXWAIT, 7, maximum wait-state MCLK cycles before forced completion (1..255)

Ports:
MCLK  in  1  master clock (48 MHz)
RST_N  in  1  asynchronous active-low reset
CPU_RST  in  NCPU  per-CPU reset, active high; CPU is ineligible for slots while high
REQ_RD  in  NCPU  CPU i requests a device read this slot
REQ_WR  in  NCPU  CPU i requests a device write this slot
DEV_DV  in  1  device read data valid
GNT  out  NCPU  one-hot grant, drives the address/data mux; all-zero means idle slot
CPU_CE  out  NCPU  one-MCLK clock-enable pulse; advances CPU i by one bus cycle
DEV_RD  out  1  read strobe to the device bus
DEV_WR  out  1  single-cycle write strobe
SLOT_ST  out  1  one-MCLK pulse on the first cycle of every slot
TIMEOUT  out  1  one-MCLK pulse when a wait is force-completed

Behaviour:
- Reset (RST_N low, asynchronous): all outputs 0; state=PICK; phase=0; last-grant pointer=NCPU-1, so CPU0 is served first after reset.
- States: PICK -> ACCESS -> (WAIT) -> PICK. The phase counter has width clog2(DIV).
- PICK (1 cycle, phase 0):
  - SLOT_ST=1.
  - Select the first i after the last-grant pointer, cyclically, with CPU_RST[i]=0. Set GNT to one-hot(i) and update the pointer.
  - If no CPU is eligible: GNT=0 and the slot runs DIV cycles with no strobes and no CE. The pointer is unchanged.
- ACCESS (phases 1..DIV-1):
  - DEV_RD = REQ_RD[g] & ~REQ_WR[g] for every cycle of the slot, including WAIT.
  - DEV_WR = REQ_WR[g], asserted only in phase DIV-1.
  - REQ_RD and REQ_WR both high: write wins and the read is suppressed.
- End of slot (phase DIV-1):
  - If no read is pending, or DEV_DV=1: CPU_CE[g]=1 for that cycle, then go to PICK.
  - If a read is pending and DEV_DV=0: go to WAIT; the wait counter starts at 0.
- WAIT:
  - GNT and DEV_RD are held; the phase is frozen and the counter increments each cycle.
  - When DEV_DV=1: CPU_CE[g]=1, go to PICK.
  - When the counter reaches MAXWAIT with DEV_DV=0: CPU_CE[g]=1 and TIMEOUT=1, go to PICK.
  - DEV_DV=1 on the same cycle as MAXWAIT: DV wins and TIMEOUT stays 0.
- A granted CPU with no request still receives CPU_CE at slot end (internal cycles).
- CPU_CE is never asserted for a non-granted CPU, and at most one bit is ever set.
- Abort: if CPU_RST[g] rises during ACCESS or WAIT:
  - Next cycle is PICK.
  - No CPU_CE, no DEV_WR and no TIMEOUT are issued for that slot.
  - DEV_RD drops with the grant.
- REQ_* inputs are sampled combinationally against the current GNT. The requesters hold them stable for the slot.
- DEV_DV is ignored outside a pending read.
- Nominal throughput with no waits and all CPUs eligible: each CPU receives one CE every NCPU*DIV MCLK.

Decomposition:
- Shared package digdug_bus_pkg:
  - state enum {PICK, ACCESS, WAIT}
  - constants NCPU_DEF=3, DIV_DEF=4, MAXWAIT_DEF=7
  - function for phase width (clog2)
- Sub-module digdug_rr_pick: combinational next-eligible finder.
  - Inputs: pointer, eligible mask.
  - Outputs: one-hot grant, index, none flag.
  - Reused by any future DMA/video requester arbiter.

Test Plan:
- Reset release, all eligible, no requests -> SLOT_ST every 4 MCLK; CPU_CE pulses 0,1,2,0,... at cycles 3,7,11,15; GNT 001,010,100 rotating.
- CPU_RST=3'b010 -> grants alternate CPU0/CPU2 only; CPU1 never receives GNT or CE; each CE is spaced 8 MCLK apart.
- CPU0 REQ_RD, DEV_DV low until 3 cycles after phase 3 -> GNT=001 held 3 extra cycles; DEV_RD high 7 cycles; CPU_CE[0] on the DV cycle; TIMEOUT=0.
- CPU1 REQ_RD, DEV_DV never rises -> exactly MAXWAIT=7 wait cycles, then TIMEOUT and CPU_CE[1] on the same cycle, then CPU2 is granted next.
- CPU2 REQ_WR, CPU_RST[2] rises in phase 2 -> no DEV_WR, no CPU_CE[2]; PICK on the next cycle grants CPU0.
- All CPU_RST=111 -> GNT=0 and CPU_CE=0 forever; SLOT_ST still pulses every 4 MCLK. Asynchronous RST_N low mid-WAIT -> all outputs 0 at once; CPU0 is granted first after release.
